// File: rtl/rle_pkg.sv
// RLE word format shared by the encoder, decoder and benches.
// Word = {run_len, colour}; run_len 0 marks end of frame.
package rle_pkg;

  localparam int RLE_LEN_BITS    = 10;
  localparam int RLE_COLOUR_BITS = 6;
  localparam int RLE_WORD_BITS   =
    RLE_LEN_BITS + RLE_COLOUR_BITS;

  typedef logic [RLE_LEN_BITS-1:0]    rle_len_t;
  typedef logic [RLE_COLOUR_BITS-1:0] rle_colour_t;
  typedef logic [RLE_WORD_BITS-1:0]   rle_word_t;

  typedef struct packed {
    rle_len_t    len;
    rle_colour_t colour;
  } rle_fields_t;

  localparam rle_word_t RLE_EOF_WORD = 16'h0000;

  function automatic rle_word_t rle_pack(
    input rle_len_t    len,
    input rle_colour_t colour
  );
    rle_fields_t f;
    f.len    = len;
    f.colour = colour;
    return rle_word_t'(f);
  endfunction

  function automatic rle_len_t rle_word_len(
    input rle_word_t w
  );
    rle_fields_t f;
    f = rle_fields_t'(w);
    return f.len;
  endfunction

  function automatic rle_colour_t rle_word_colour(
    input rle_word_t w
  );
    rle_fields_t f;
    f = rle_fields_t'(w);
    return f.colour;
  endfunction

endpackage

// File: rtl/rle_encoder_if.sv
// Pixel-in / word-out handshake bundle of the RLE encoder.
// master = pixel source + word sink, slave = encoder.
interface rle_encoder_if;
  import rle_pkg::*;

  logic        pixel_valid;
  rle_colour_t pixel_colour;
  logic        pixel_eol;
  logic        pixel_ready;
  logic        frame_done;
  logic        word_valid;
  rle_word_t   word_data;
  logic        word_ready;

  modport master (
    output pixel_valid,
    output pixel_colour,
    output pixel_eol,
    output frame_done,
    output word_ready,
    input  pixel_ready,
    input  word_valid,
    input  word_data
  );

  modport slave (
    input  pixel_valid,
    input  pixel_colour,
    input  pixel_eol,
    input  frame_done,
    input  word_ready,
    output pixel_ready,
    output word_valid,
    output word_data
  );

endinterface

// File: rtl/rle_word_fifo.sv
// Word FIFO with two push ports and one pop port.
// push1 is only ever used together with push0.
module rle_word_fifo
  import rle_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push0,
  input  logic                   push1,
  input  rle_word_t              data0,
  input  rle_word_t              data1,
  input  logic                   pop,
  output logic                   valid,
  output rle_word_t              head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  rle_word_t      mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  wr_ptr1;
  logic [AW-1:0]  rd_ptr;
  logic           do_pop;

  assign wr_ptr1 = wr_ptr + AW'(1);
  assign valid   = count != '0;
  assign do_pop  = pop && valid;
  assign head    = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push0) mem[wr_ptr]  <= data0;
    if (push1) mem[wr_ptr1] <= data1;
  end

  // Power-of-two depth lets the pointers wrap for free.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push0)
                       + AW'(push1);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count  <= count + CW'(push0)
                      + CW'(push1)
                      - CW'(do_pop);
    end
  end

endmodule

// File: rtl/rle_encoder.sv
// Streaming run-length encoder: 6-bit pixels in,
// {run_len, colour} words and an EOF marker out.
module rle_encoder
  import rle_pkg::*;
#(
  parameter int MAX_RUN    = 1023,
  parameter int FIFO_DEPTH = 4
) (
  input logic         clk,
  input logic         rst,
  rle_encoder_if.slave bus
);

  localparam int       CW      =
    $clog2(FIFO_DEPTH) + 1;
  localparam rle_len_t MAX_LEN =
    rle_len_t'(MAX_RUN);

  logic        run_open;
  rle_colour_t run_colour;
  rle_len_t    run_cnt;

  logic        open_nxt;
  rle_colour_t colour_nxt;
  rle_len_t    cnt_nxt;

  logic        push0;
  logic        push1;
  rle_word_t   data0;
  rle_word_t   data1;
  logic        pop;
  logic [CW-1:0] count;
  logic [CW-1:0] free_slots;

  logic pixel_take;
  logic frame_take;

  // Two free slots cover the worst case of two pushes.
  assign free_slots      = CW'(FIFO_DEPTH) - count;
  assign bus.pixel_ready = !rst &&
                           free_slots >= CW'(2);

  assign pixel_take = bus.pixel_valid &&
                      bus.pixel_ready;
  assign frame_take = bus.frame_done &&
                      bus.pixel_ready &&
                      !bus.pixel_valid;

  assign pop = bus.word_valid && bus.word_ready;

  always_comb begin
    open_nxt   = run_open;
    colour_nxt = run_colour;
    cnt_nxt    = run_cnt;
    push0      = 1'b0;
    push1      = 1'b0;
    data0      = '0;
    data1      = '0;
    unique case (1'b1)
      pixel_take: begin
        if (run_open &&
            bus.pixel_colour == run_colour) begin
          cnt_nxt = run_cnt + rle_len_t'(1);
        end else begin
          if (run_open) begin
            push0 = 1'b1;
            data0 = rle_pack(run_cnt, run_colour);
          end
          colour_nxt = bus.pixel_colour;
          cnt_nxt    = rle_len_t'(1);
        end
        open_nxt = 1'b1;
        if (cnt_nxt == MAX_LEN || bus.pixel_eol) begin
          open_nxt = 1'b0;
          if (push0) begin
            push1 = 1'b1;
            data1 = rle_pack(cnt_nxt, colour_nxt);
          end else begin
            push0 = 1'b1;
            data0 = rle_pack(cnt_nxt, colour_nxt);
          end
        end
      end
      frame_take: begin
        open_nxt = 1'b0;
        push0    = 1'b1;
        if (run_open) begin
          data0 = rle_pack(run_cnt, run_colour);
          push1 = 1'b1;
          data1 = RLE_EOF_WORD;
        end else begin
          data0 = RLE_EOF_WORD;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_open   <= 1'b0;
      run_colour <= '0;
      run_cnt    <= '0;
    end else begin
      run_open   <= open_nxt;
      run_colour <= colour_nxt;
      run_cnt    <= cnt_nxt;
    end
  end

  rle_word_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push0 (push0),
    .push1 (push1),
    .data0 (data0),
    .data1 (data1),
    .pop   (pop),
    .valid (bus.word_valid),
    .head  (bus.word_data),
    .count (count)
  );

endmodule

// File: tb/tb_rle_encoder.sv
// Self-checking bench for rle_encoder: vector table,
// directed corner sequences and a random run model.
module tb_rle_encoder;
  import rle_pkg::*;

  localparam int MAXR = 1023;

  logic clk = 1'b0;
  logic rst = 1'b1;

  rle_encoder_if bus();

  rle_encoder #(
    .MAX_RUN    (MAXR),
    .FIFO_DEPTH (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [15:0] got [$];
  logic [15:0] exp [$];
  logic [5:0]  seg [$];

  logic        rr_mode  = 1'b0;
  logic        wr_fixed = 1'b1;
  logic        hold     = 1'b0;
  logic [15:0] hold_data;

  typedef struct {
    logic        v;
    logic        f;
    logic [5:0]  c;
    logic        e;
    int          nw;
    logic [15:0] w0;
    logic [15:0] w1;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h want %0h",
               name, act, req);
    end
  endtask

  // Sink: word_ready changes just after each rising edge.
  always @(posedge clk) begin
    #1;
    bus.word_ready = rr_mode ?
      ($urandom_range(0, 3) != 0) : wr_fixed;
  end

  // Collect handshakes and check head stability under stall.
  always @(negedge clk) begin
    if (rst) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("hold_valid", 32'(bus.word_valid), 32'd1);
        chk("hold_data", 32'(bus.word_data),
            32'(hold_data));
      end
      if (bus.word_valid && bus.word_ready)
        got.push_back(bus.word_data);
      hold      = bus.word_valid && !bus.word_ready;
      hold_data = bus.word_data;
    end
  end

  function automatic void m_flush();
    int i = 0;
    while (i < seg.size()) begin
      logic [5:0] c;
      int n;
      c = seg[i];
      n = 0;
      while (i < seg.size() && seg[i] == c &&
             n < MAXR) begin
        n++;
        i++;
      end
      exp.push_back({n[9:0], c});
    end
    seg.delete();
  endfunction

  function automatic void m_pixel(input logic [5:0] c,
                                  input logic e);
    seg.push_back(c);
    if (e) m_flush();
  endfunction

  function automatic void m_fd();
    m_flush();
    exp.push_back(16'h0000);
  endfunction

  task automatic step(input logic v,
                      input logic [5:0] c,
                      input logic e,
                      input logic f);
    int n = 0;
    bus.pixel_valid  = v;
    bus.pixel_colour = c;
    bus.pixel_eol    = e;
    bus.frame_done   = f;
    @(negedge clk);
    while (!bus.pixel_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      failures++;
      $display("FAIL step_timeout: ready 0 want 1");
    end
    @(posedge clk);
    #1;
    bus.pixel_valid = 1'b0;
    bus.pixel_eol   = 1'b0;
    bus.frame_done  = 1'b0;
  endtask

  task automatic drain_cmp(input string name);
    int n = 0;
    rr_mode  = 1'b0;
    wr_fixed = 1'b1;
    repeat (3) @(negedge clk);
    while (bus.word_valid && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      checks++;
      failures++;
      $display("FAIL %s_drain: valid 1 want 0", name);
    end
    @(posedge clk);
    #1;
    chk({name, "_count"}, 32'(got.size()),
        32'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      chk(name,
          i < got.size() ? 32'(got[i]) : 32'hDEAD,
          32'(exp[i]));
    got.delete();
    exp.delete();
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] c;
    logic       eol;
    int         len;
    logic       lng;

    bus.pixel_valid  = 1'b0;
    bus.pixel_colour = '0;
    bus.pixel_eol    = 1'b0;
    bus.frame_done   = 1'b0;

    tbl[0]  = '{1'b1, 1'b0, 6'h01, 1'b0, 0, 16'h0, 16'h0};
    tbl[1]  = '{1'b1, 1'b0, 6'h01, 1'b0, 0, 16'h0, 16'h0};
    tbl[2]  = '{1'b1, 1'b0, 6'h02, 1'b0, 1, 16'h0081, 16'h0};
    tbl[3]  = '{1'b1, 1'b0, 6'h03, 1'b1, 2, 16'h0042, 16'h0043};
    tbl[4]  = '{1'b1, 1'b0, 6'h0A, 1'b0, 0, 16'h0, 16'h0};
    tbl[5]  = '{1'b1, 1'b0, 6'h0A, 1'b0, 0, 16'h0, 16'h0};
    tbl[6]  = '{1'b1, 1'b0, 6'h0A, 1'b0, 0, 16'h0, 16'h0};
    tbl[7]  = '{1'b0, 1'b1, 6'h00, 1'b0, 2, 16'h00CA, 16'h0000};
    tbl[8]  = '{1'b0, 1'b1, 6'h00, 1'b0, 1, 16'h0000, 16'h0};
    tbl[9]  = '{1'b1, 1'b0, 6'h07, 1'b1, 1, 16'h0047, 16'h0};
    tbl[10] = '{1'b1, 1'b0, 6'h07, 1'b1, 1, 16'h0047, 16'h0};
    tbl[11] = '{1'b1, 1'b1, 6'h09, 1'b1, 1, 16'h0049, 16'h0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pixel_ready", 32'(bus.pixel_ready), 32'd0);
    chk("rst_word_valid", 32'(bus.word_valid), 32'd0);
    chk("rst_word_data", 32'(bus.word_data), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(bus.pixel_ready), 32'd1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 640; i++)
      step(1'b1, 6'h3F, i == 639, 1'b0);
    exp.push_back(16'hA03F);
    drain_cmp("run640");

    for (int i = 0; i < 2000; i++)
      step(1'b1, 6'h05, i == 1999, 1'b0);
    exp.push_back(16'hFFC5);
    exp.push_back(16'hF445);
    drain_cmp("run2000");

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].v, tbl[i].c, tbl[i].e, tbl[i].f);
      if (tbl[i].nw > 0) exp.push_back(tbl[i].w0);
      if (tbl[i].nw > 1) exp.push_back(tbl[i].w1);
    end
    drain_cmp("table");

    wr_fixed = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    step(1'b1, 6'h21, 1'b1, 1'b0);
    step(1'b1, 6'h22, 1'b1, 1'b0);
    step(1'b1, 6'h23, 1'b1, 1'b0);
    exp.push_back(16'h0061);
    exp.push_back(16'h0062);
    exp.push_back(16'h0063);
    @(negedge clk);
    chk("bp_ready", 32'(bus.pixel_ready), 32'd0);
    chk("bp_valid", 32'(bus.word_valid), 32'd1);
    chk("bp_head", 32'(bus.word_data), 32'h0061);
    repeat (5) @(negedge clk);
    chk("bp_ready_held", 32'(bus.pixel_ready), 32'd0);
    @(posedge clk);
    #1;
    wr_fixed = 1'b1;
    step(1'b1, 6'h24, 1'b1, 1'b0);
    exp.push_back(16'h0064);
    drain_cmp("backpressure");

    for (int i = 0; i < 5; i++)
      step(1'b1, 6'h11, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ready", 32'(bus.pixel_ready), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("midrst_valid", 32'(bus.word_valid), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b1, 6'h11, 1'b0, 1'b0);
    step(1'b1, 6'h11, 1'b1, 1'b0);
    exp.push_back(16'h0091);
    drain_cmp("reset_midrun");

    rr_mode = 1'b1;
    c = '0;
    for (int r = 0; r < 60; r++) begin
      len = $urandom_range(1, 40);
      lng = ($urandom_range(0, 11) == 0);
      if (lng) len = $urandom_range(1020, 1030);
      for (int p = 0; p < len; p++) begin
        if (p == 0 ||
            (!lng && $urandom_range(0, 9) < 3))
          c = 6'($urandom_range(0, 63));
        eol = (p == len - 1) &&
              ($urandom_range(0, 3) != 0);
        m_pixel(c, eol);
        step(1'b1, c, eol, 1'b0);
      end
      if ($urandom_range(0, 7) == 0) begin
        m_fd();
        step(1'b0, 6'h00, 1'b0, 1'b1);
      end
    end
    m_fd();
    step(1'b0, 6'h00, 1'b0, 1'b1);
    drain_cmp("random");

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
